// File: rtl/alu_8bit.sv
// 8-bit ALU: sixteen arithmetic/logic/shift/compare operations on unsigned operands,
// with the result and carry/borrow/shift-out flag registered once per clock.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_Out,
    output logic       CarryOut
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LT   = 4'h8,
        OP_EQ   = 4'h9,
        OP_GT   = 4'hA,
        OP_NAND = 4'hB,
        OP_NOR  = 4'hC,
        OP_XNOR = 4'hD,
        OP_ROL  = 4'hE,
        OP_ROR  = 4'hF
    } op_e;

    op_e               op_c;
    logic [DATA_W:0]   sum_c;
    logic [DATA_W:0]   diff_c;
    logic [DATA_W-1:0] result_c;
    logic              carry_c;

    assign op_c = op_e'(ALU_Sel);

    // Widened by one bit so the MSB is the carry (add) or borrow (sub).
    assign sum_c  = {1'b0, A} + {1'b0, B};
    assign diff_c = {1'b0, A} - {1'b0, B};

    // Every opcode is decoded explicitly; no path yields X.
    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        case (op_c)
            OP_ADD: begin
                result_c = sum_c[DATA_W-1:0];
                carry_c  = sum_c[DATA_W];
            end
            OP_SUB: begin
                result_c = diff_c[DATA_W-1:0];
                carry_c  = diff_c[DATA_W];
            end
            OP_AND:  result_c = A & B;
            OP_OR:   result_c = A | B;
            OP_XOR:  result_c = A ^ B;
            OP_NOT:  result_c = ~A;
            OP_SHL: begin
                result_c = {A[DATA_W-2:0], 1'b0};
                carry_c  = A[DATA_W-1];
            end
            OP_SHR: begin
                result_c = {1'b0, A[DATA_W-1:1]};
                carry_c  = A[0];
            end
            OP_LT:   result_c = DATA_W'(A < B);
            OP_EQ:   result_c = DATA_W'(A == B);
            OP_GT:   result_c = DATA_W'(A > B);
            OP_NAND: result_c = ~(A & B);
            OP_NOR:  result_c = ~(A | B);
            OP_XNOR: result_c = ~(A ^ B);
            OP_ROL: begin
                result_c = {A[DATA_W-2:0], A[DATA_W-1]};
                carry_c  = A[DATA_W-1];
            end
            OP_ROR: begin
                result_c = {A[0], A[DATA_W-1:1]};
                carry_c  = A[0];
            end
        endcase
    end

    // Output registers; synchronous reset wins over any operation on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Out  <= '0;
            CarryOut <= 1'b0;
        end else begin
            ALU_Out  <= result_c;
            CarryOut <= carry_c;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed vectors with literal expectations plus
// random traffic checked against an integer-arithmetic reference model.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;

    typedef struct {
        logic [7:0] out;
        logic       c;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_Out (ALU_Out),
        .CarryOut(CarryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   r;
        int   c;
        r = 0;
        c = 0;
        case (op)
            0:  begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  begin r = (a * 2) % 256; c = a / 128; end
            7:  begin r = a / 2; c = a % 2; end
            8:  r = (a < b) ? 1 : 0;
            9:  r = (a == b) ? 1 : 0;
            10: r = (a > b) ? 1 : 0;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = 255 - (a ^ b);
            14: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
            default: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
        endcase
        e.out  = 8'(r);
        e.c    = 1'(c);
        e.name = $sformatf("op%0d a=%02h b=%02h", op, a, b);
        return e;
    endfunction

    task automatic drive(input logic r, input int op, input int a, input int b);
        @(negedge clk);
        rst     = r;
        ALU_Sel = 4'(op);
        A       = 8'(a);
        B       = 8'(b);
    endtask

    task automatic do_reset(input string name);
        exp_t e;
        drive(1'b1, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        e.out  = 8'h00;
        e.c    = 1'b0;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic issue_exp(input int op, input int a, input int b,
                             input logic [7:0] out, input logic c, input string name);
        exp_t e;
        drive(1'b0, op, a, b);
        e.out  = out;
        e.c    = c;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic issue_rand();
        int op;
        int a;
        int b;
        op = $urandom_range(0, 15);
        a  = $urandom_range(0, 255);
        b  = $urandom_range(0, 255);
        if ($urandom_range(0, 7) == 0) b = a;
        drive(1'b0, op, a, b);
        sb.push_back(model(op, a, b));
    endtask

    // Monitor: each edge after an issued op, the registered output is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (ALU_Out !== e.out || CarryOut !== e.c) begin
                    n_fail++;
                    $display("FAIL %s: got %02h/%0b expected %02h/%0b",
                             e.name, ALU_Out, CarryOut, e.out, e.c);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0;

        do_reset("reset edge 1");
        do_reset("reset edge 2");

        issue_exp(0, 8'h0A, 8'h02, 8'h0C, 1'b0, "ADD 0A+02");
        issue_exp(1, 8'h0A, 8'h02, 8'h08, 1'b0, "SUB 0A-02");
        issue_exp(2, 8'h0A, 8'h02, 8'h02, 1'b0, "AND");
        issue_exp(3, 8'h0A, 8'h02, 8'h0A, 1'b0, "OR");
        issue_exp(4, 8'h0A, 8'h02, 8'h08, 1'b0, "XOR");
        issue_exp(5, 8'h0A, 8'h02, 8'hF5, 1'b0, "NOT");
        issue_exp(6, 8'h0A, 8'h02, 8'h14, 1'b0, "SHL 0A");
        issue_exp(7, 8'h0A, 8'h02, 8'h05, 1'b0, "SHR 0A");
        issue_exp(8, 8'h0A, 8'h02, 8'h00, 1'b0, "LT 0A<02");
        issue_exp(9, 8'h0A, 8'h02, 8'h00, 1'b0, "EQ 0A==02");

        issue_exp(0, 8'hFF, 8'h01, 8'h00, 1'b1, "ADD wrap FF+01");
        issue_exp(1, 8'h01, 8'h02, 8'hFF, 1'b1, "SUB borrow 01-02");
        issue_exp(1, 8'h00, 8'h01, 8'hFF, 1'b1, "SUB underflow 00-01");
        issue_exp(6, 8'h81, 8'h00, 8'h02, 1'b1, "SHL 81");
        issue_exp(7, 8'h81, 8'h00, 8'h40, 1'b1, "SHR 81");

        issue_exp(8,  8'h03, 8'h05, 8'h01, 1'b0, "LT 03<05");
        issue_exp(10, 8'h03, 8'h05, 8'h00, 1'b0, "GT 03>05");
        issue_exp(9,  8'h03, 8'h05, 8'h00, 1'b0, "EQ 03==05");
        issue_exp(9,  8'h5A, 8'h5A, 8'h01, 1'b0, "EQ 5A==5A");
        issue_exp(8,  8'h5A, 8'h5A, 8'h00, 1'b0, "LT 5A<5A");
        issue_exp(10, 8'h5A, 8'h5A, 8'h00, 1'b0, "GT 5A>5A");
        issue_exp(1,  8'h5A, 8'h5A, 8'h00, 1'b0, "SUB 5A-5A");

        issue_exp(10, 8'h0A, 8'h02, 8'h01, 1'b0, "GT 0A>02");
        issue_exp(11, 8'h0A, 8'h02, 8'hFD, 1'b0, "NAND");
        issue_exp(12, 8'h0A, 8'h02, 8'hF5, 1'b0, "NOR");
        issue_exp(13, 8'h0A, 8'h02, 8'hF7, 1'b0, "XNOR");
        issue_exp(14, 8'h0A, 8'h02, 8'h14, 1'b0, "ROL 0A");
        issue_exp(15, 8'h01, 8'h02, 8'h80, 1'b1, "ROR 01");
        issue_exp(14, 8'h81, 8'h00, 8'h03, 1'b1, "ROL 81");

        // Reset in the middle of traffic replaces the in-flight result.
        issue_exp(0, 8'hFF, 8'hFF, 8'hFE, 1'b1, "ADD FF+FF");
        do_reset("mid-stream reset");
        issue_exp(5, 8'h00, 8'h00, 8'hFF, 1'b0, "NOT after reset");

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) do_reset("random-phase reset");
            else issue_rand();
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
